// File: rtl/countdown_timer_ctrl.sv
// ---------------------------------------------------------------------------
// countdown_timer_ctrl
//
// Seconds down-counter with load / start / pause control. A preset from the
// switches is loaded, then the count falls by one every TICK_DIV clocks until
// it reaches zero, where the block parks in DONE until the next load or reset.
// Binary count plus BCD tens/units digits feed the HEX1/HEX0 decoders.
//
// Ports
//   clk         system clock (CLOCK_50)
//   rst         asynchronous, active-high reset
//   load        raw key level; a rising edge loads the preset
//   start_stop  raw key level; a rising edge starts / pauses / resumes
//   preset      switch value, sampled on the load action
//   count       remaining seconds (binary)
//   tens        count / 10 (BCD)
//   units       count % 10 (BCD)
//   running     1 while in RUN
//   done        1 while in DONE
// ---------------------------------------------------------------------------
module countdown_timer_ctrl #(
    parameter int IN       = 7,
    parameter int MAX_VAL  = 99,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          start_stop,
    input  logic [IN-1:0] preset,
    output logic [IN-1:0] count,
    output logic [3:0]    tens,
    output logic [3:0]    units,
    output logic          running,
    output logic          done
);

    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [IN-1:0] MAX_COUNT = IN'(MAX_VAL);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    logic          load_s1_q, load_s2_q, load_prev_q;
    logic          start_s1_q, start_s2_q, start_prev_q;
    logic          load_pulse, start_pulse, tick;

    state_t        state_q, state_d;
    logic [IN-1:0] count_q, count_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          running_q, running_d;
    logic          done_q, done_d;

    logic [IN-1:0] tens_full, units_full;

    // One-cycle pulses on the synchronised rising edge; a held key stays high
    // in both sync2 and prev, so it only ever produces a single pulse.
    assign load_pulse  = load_s2_q & ~load_prev_q;
    assign start_pulse = start_s2_q & ~start_prev_q;

    assign tick = (state_q == RUN) && (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        tick_cnt_d = tick_cnt_q;

        if (load_pulse) begin
            // Load wins over a same-cycle start edge, which is simply dropped.
            count_d    = (preset > MAX_COUNT) ? MAX_COUNT : preset;
            tick_cnt_d = '0;
            state_d    = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_pulse) begin
                        state_d = (count_q == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
                    if (start_pulse) begin
                        state_d = PAUSE;
                    end
                    // A coinciding tick still decrements; reaching zero
                    // overrides a pause requested on the same edge.
                    if (tick) begin
                        if (count_q != '0) begin
                            count_d = count_q - 1'b1;
                        end
                        if (count_q <= IN'(1)) begin
                            state_d    = DONE;
                            tick_cnt_d = '0;
                        end
                    end
                end
                PAUSE: begin
                    // tick_cnt holds, so resuming keeps the partial second.
                    if (start_pulse) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    count_d    = '0;
                    tick_cnt_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_s1_q    <= 1'b0;
            load_s2_q    <= 1'b0;
            load_prev_q  <= 1'b0;
            start_s1_q   <= 1'b0;
            start_s2_q   <= 1'b0;
            start_prev_q <= 1'b0;
            state_q      <= IDLE;
            count_q      <= '0;
            tick_cnt_q   <= '0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            load_s1_q    <= load;
            load_s2_q    <= load_s1_q;
            load_prev_q  <= load_s2_q;
            start_s1_q   <= start_stop;
            start_s2_q   <= start_s1_q;
            start_prev_q <= start_s2_q;
            state_q      <= state_d;
            count_q      <= count_d;
            tick_cnt_q   <= tick_cnt_d;
            running_q    <= running_d;
            done_q       <= done_d;
        end
    end

    // count never exceeds MAX_VAL, so the quotient always fits one BCD digit.
    assign tens_full  = count_q / IN'(10);
    assign units_full = count_q % IN'(10);

    assign count   = count_q;
    assign tens    = tens_full[3:0];
    assign units   = units_full[3:0];
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer_ctrl
//
// Directed bench for countdown_timer_ctrl with TICK_DIV = 4. Inputs change
// 1 time unit after a rising edge and outputs are sampled at the same point.
// A key raised just after edge K takes effect on edge K+3 (two sync flops,
// then the edge-detect pulse is consumed).
// ---------------------------------------------------------------------------
module tb_countdown_timer_ctrl;

    logic       clk;
    logic       rst;
    logic       load;
    logic       start_stop;
    logic [6:0] preset;
    logic [6:0] count;
    logic [3:0] tens;
    logic [3:0] units;
    logic       running;
    logic       done;

    int checks = 0;
    int errors = 0;

    countdown_timer_ctrl #(
        .IN(7),
        .MAX_VAL(99),
        .TICK_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .start_stop(start_stop),
        .preset(preset),
        .count(count),
        .tens(tens),
        .units(units),
        .running(running),
        .done(done)
    );

    // 10-unit clock period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 unit past the last one.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the key levels and switch value.
    task automatic applyStimulus(input logic l, input logic s, input logic [6:0] p);
        load       = l;
        start_stop = s;
        preset     = p;
    endtask

    // Compare every output against hand-computed expectations.
    task automatic checkOutput(input string tag, input int expCount, input int expTens,
                               input int expUnits, input logic expRunning,
                               input logic expDone);
        checks++;
        assert (count === 7'(expCount)) else begin
            errors++;
            $error("[TB] FAIL %s count: got %0d expected %0d", tag, count, expCount);
        end
        checks++;
        assert (tens === 4'(expTens)) else begin
            errors++;
            $error("[TB] FAIL %s tens: got %0d expected %0d", tag, tens, expTens);
        end
        checks++;
        assert (units === 4'(expUnits)) else begin
            errors++;
            $error("[TB] FAIL %s units: got %0d expected %0d", tag, units, expUnits);
        end
        checks++;
        assert (running === expRunning) else begin
            errors++;
            $error("[TB] FAIL %s running: got %b expected %b", tag, running, expRunning);
        end
        checks++;
        assert (done === expDone) else begin
            errors++;
            $error("[TB] FAIL %s done: got %b expected %b", tag, done, expDone);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 7'd0);
        waitCycles(2);
        checkOutput("reset", 0, 0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        waitCycles(1);

        // Load 25 and count down at one step per 4 clocks.
        $display("[TB] load 25 and run");
        applyStimulus(1'b1, 1'b0, 7'd25);
        waitCycles(3);
        checkOutput("load25", 25, 2, 5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd25);
        waitCycles(3);
        applyStimulus(1'b0, 1'b1, 7'd25);
        waitCycles(3);
        checkOutput("start25", 25, 2, 5, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd25);
        waitCycles(3);
        checkOutput("run25_e3", 25, 2, 5, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("run24", 24, 2, 4, 1'b1, 1'b0);
        waitCycles(4);
        checkOutput("run23", 23, 2, 3, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a run at 37.
        $display("[TB] async reset mid-run");
        applyStimulus(1'b1, 1'b0, 7'd37);
        waitCycles(3);
        checkOutput("load37", 37, 3, 7, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd37);
        waitCycles(3);
        applyStimulus(1'b0, 1'b1, 7'd37);
        waitCycles(3);
        checkOutput("start37", 37, 3, 7, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd37);
        waitCycles(2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst", 0, 0, 0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        waitCycles(1);
        checkOutput("after_rst", 0, 0, 0, 1'b0, 1'b0);

        // Short run from 2 down to DONE, then a start edge that is ignored.
        $display("[TB] run 2 to done");
        applyStimulus(1'b1, 1'b0, 7'd2);
        waitCycles(3);
        applyStimulus(1'b0, 1'b0, 7'd2);
        waitCycles(3);
        applyStimulus(1'b0, 1'b1, 7'd2);
        waitCycles(3);
        checkOutput("start2", 2, 0, 2, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd2);
        waitCycles(4);
        checkOutput("run1", 1, 0, 1, 1'b1, 1'b0);
        waitCycles(3);
        checkOutput("run1_e7", 1, 0, 1, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("hit0", 0, 0, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 7'd2);
        waitCycles(3);
        checkOutput("done_start", 0, 0, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 7'd2);
        waitCycles(3);

        // Pause at 8 with a partial second elapsed, then resume.
        $display("[TB] pause and resume");
        applyStimulus(1'b1, 1'b0, 7'd10);
        waitCycles(3);
        applyStimulus(1'b0, 1'b0, 7'd10);
        waitCycles(3);
        applyStimulus(1'b0, 1'b1, 7'd10);
        waitCycles(3);
        checkOutput("start10", 10, 1, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd10);
        waitCycles(7);
        checkOutput("run9", 9, 0, 9, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 7'd10);
        waitCycles(1);
        checkOutput("run8", 8, 0, 8, 1'b1, 1'b0);
        waitCycles(2);
        checkOutput("paused", 8, 0, 8, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd10);
        waitCycles(20);
        checkOutput("paused_hold", 8, 0, 8, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 7'd10);
        waitCycles(3);
        checkOutput("resumed", 8, 0, 8, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd10);
        waitCycles(1);
        checkOutput("resume_e1", 8, 0, 8, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("resume_dec", 7, 0, 7, 1'b1, 1'b0);

        // Saturating preset, then a zero preset that goes straight to DONE.
        $display("[TB] saturation and zero preset");
        applyStimulus(1'b1, 1'b0, 7'd120);
        waitCycles(3);
        checkOutput("sat120", 99, 9, 9, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd120);
        waitCycles(3);
        applyStimulus(1'b1, 1'b0, 7'd0);
        waitCycles(3);
        checkOutput("load0", 0, 0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd0);
        waitCycles(3);
        applyStimulus(1'b0, 1'b1, 7'd0);
        waitCycles(2);
        checkOutput("zero_pre", 0, 0, 0, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("zero_done", 0, 0, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 7'd0);
        waitCycles(3);

        // Load and start rising together during RUN, then both keys held.
        $display("[TB] simultaneous load and start");
        applyStimulus(1'b1, 1'b0, 7'd6);
        waitCycles(3);
        applyStimulus(1'b0, 1'b0, 7'd6);
        waitCycles(3);
        applyStimulus(1'b0, 1'b1, 7'd6);
        waitCycles(3);
        applyStimulus(1'b0, 1'b0, 7'd6);
        waitCycles(4);
        checkOutput("run5", 5, 0, 5, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 7'd42);
        waitCycles(3);
        checkOutput("load_wins", 42, 4, 2, 1'b0, 1'b0);
        waitCycles(50);
        checkOutput("held_keys", 42, 4, 2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd42);
        waitCycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
